// File: rtl/sram_arbiter_if.sv
// sram_arbiter_if: SRAM-like request/response bundle shared by the requesters and the downstream port
interface sram_arbiter_if;
    logic        req;
    logic        wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] rdata;

    modport master (output req, wr, size, addr, wdata, input addr_ok, data_ok, rdata);
    modport slave  (input req, wr, size, addr, wdata, output addr_ok, data_ok, rdata);
endinterface

// File: rtl/sram_arbiter.sv
// sram_arbiter: merges instruction and data SRAM-like ports onto one downstream port, in-order responses
module sram_arbiter #(
    parameter int DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    sram_arbiter_if.slave        i,
    sram_arbiter_if.slave        d,
    sram_arbiter_if.master       m,
    output logic                 busy,
    output logic                 err_stray
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [CW-1:0]    count;
    logic [AW-1:0]    wp, rp;
    logic [DEPTH-1:0] owner_q;
    logic             lock, lock_d, last_d;
    logic             grant_d, full, accept, pop, head;

    // Grant selection: a held lock wins while its owner still requests, otherwise round-robin
    always_comb begin
        full    = (count == CW'(DEPTH));
        grant_d = (lock && (lock_d ? d.req : i.req)) ? lock_d
                : (i.req && d.req)                   ? ~last_d
                :                                      d.req;
    end

    assign m.req     = rst & (i.req | d.req) & ~full;
    assign m.wr      = grant_d ? d.wr    : i.wr;
    assign m.size    = grant_d ? d.size  : i.size;
    assign m.addr    = grant_d ? d.addr  : i.addr;
    assign m.wdata   = grant_d ? d.wdata : i.wdata;
    assign accept    = m.req & m.addr_ok;
    assign i.addr_ok = accept & ~grant_d;
    assign d.addr_ok = accept & grant_d;
    assign pop       = m.data_ok & (count != '0);
    assign head      = owner_q[rp];
    assign i.data_ok = pop & ~head;
    assign d.data_ok = pop & head;
    assign i.rdata   = m.rdata;
    assign d.rdata   = m.rdata;
    assign busy      = (count != '0);

    // Owner FIFO, occupancy, lock and round-robin history; a reset drops everything outstanding
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count     <= '0;
            wp        <= '0;
            rp        <= '0;
            owner_q   <= '0;
            lock      <= 1'b0;
            lock_d    <= 1'b0;
            last_d    <= 1'b0;
            err_stray <= 1'b0;
        end else begin
            if (accept) begin
                owner_q[wp] <= grant_d;
                wp          <= wp + AW'(1);
                last_d      <= grant_d;
            end
            if (pop)
                rp <= rp + AW'(1);
            count  <= count + CW'(accept) - CW'(pop);
            lock   <= m.req & ~m.addr_ok;
            lock_d <= grant_d;
            if (m.data_ok && count == '0)
                err_stray <= 1'b1;
        end
    end
endmodule

// File: tb/tb_sram_arbiter.sv
// tb_sram_arbiter: directed vectors with hand-computed expectations for sram_arbiter
module tb_sram_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b0;
    logic busy, err_stray;
    int   checks = 0;
    int   errors = 0;

    localparam logic [31:0] IA = 32'h0000_0100;
    localparam logic [31:0] DA = 32'h0000_0200;

    sram_arbiter_if ib ();
    sram_arbiter_if db ();
    sram_arbiter_if mb ();

    sram_arbiter #(.DEPTH(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .i         (ib),
        .d         (db),
        .m         (mb),
        .busy      (busy),
        .err_stray (err_stray)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic ir, input logic dr, input logic aok, input logic dok);
        ib.req        = ir;
        db.req        = dr;
        mb.addr_ok    = aok;
        mb.data_ok    = dok;
        #1;
    endtask

    task automatic oks(input string tag, input logic [3:0] exp);
        check(tag, {28'd0, ib.addr_ok, db.addr_ok, ib.data_ok, db.data_ok}, {28'd0, exp});
    endtask

    initial begin
        ib.req = 0; ib.wr = 0; ib.size = 2'd1; ib.addr = IA; ib.wdata = 32'h1111_1111;
        db.req = 0; db.wr = 1; db.size = 2'd2; db.addr = DA; db.wdata = 32'hDEAD_BEEF;
        mb.addr_ok = 0; mb.data_ok = 0; mb.rdata = 32'h0;
        // reset holds outputs low even with requests pending
        #2;
        drive(1, 1, 1, 1);
        check("rst_mreq", mb.req, 0);
        check("rst_busy", busy, 0);
        oks("rst_oks", 4'b0000);
        check("rst_stray", err_stray, 0);
        drive(0, 0, 0, 0);
        #10 rst = 1'b1;
        tick();
        // single I read
        ib.addr = 32'hBFC0_0000;
        drive(1, 0, 1, 0);
        check("rd_mreq", mb.req, 1);
        check("rd_maddr", mb.addr, 32'hBFC0_0000);
        check("rd_mwr", mb.wr, 0);
        oks("rd_accept", 4'b1000);
        check("rd_busy0", busy, 0);
        tick();
        drive(0, 0, 0, 0);
        check("rd_busy1", busy, 1);
        oks("rd_wait1", 4'b0000);
        tick();
        check("rd_busy2", busy, 1);
        tick();
        mb.rdata = 32'h3C08_0001;
        drive(0, 0, 0, 1);
        oks("rd_data", 4'b0010);
        check("rd_rdata", ib.rdata, 32'h3C08_0001);
        check("rd_busy3", busy, 1);
        tick();
        drive(0, 0, 0, 0);
        check("rd_busy4", busy, 0);
        ib.addr = IA;
        // contention: last owner is I, so D first, alternating
        drive(1, 1, 1, 0);
        check("ct_maddr0", mb.addr, DA);
        check("ct_mwr0", mb.wr, 1);
        check("ct_wdata0", mb.wdata, 32'hDEAD_BEEF);
        check("ct_size0", mb.size, 2);
        oks("ct_acc0", 4'b0100);
        tick();
        drive(1, 1, 1, 0);
        check("ct_maddr1", mb.addr, IA);
        check("ct_size1", mb.size, 1);
        oks("ct_acc1", 4'b1000);
        tick();
        drive(1, 1, 1, 0);
        oks("ct_acc2", 4'b0100);
        tick();
        drive(1, 1, 1, 0);
        oks("ct_acc3", 4'b1000);
        tick();
        // full: requests blocked
        drive(1, 1, 1, 0);
        check("fl_mreq", mb.req, 0);
        oks("fl_noacc", 4'b0000);
        tick();
        drive(1, 1, 1, 1);
        check("fl_mreq_pop", mb.req, 0);
        oks("fl_pop_d", 4'b0001);
        tick();
        drive(1, 1, 1, 1);
        check("fl_mreq_reopen", mb.req, 1);
        oks("fl_acc_pop", 4'b0110);
        tick();
        drive(1, 1, 1, 0);
        oks("fl_acc_i", 4'b1000);
        tick();
        drive(1, 1, 1, 0);
        check("fl_mreq_full", mb.req, 0);
        tick();
        // drain in order D, I, D, I
        drive(0, 0, 0, 1);
        oks("dr0", 4'b0001);
        tick();
        drive(0, 0, 0, 1);
        oks("dr1", 4'b0010);
        tick();
        drive(0, 0, 0, 1);
        oks("dr2", 4'b0001);
        tick();
        drive(0, 0, 0, 1);
        oks("dr3", 4'b0010);
        tick();
        drive(0, 0, 0, 0);
        check("dr_busy", busy, 0);
        // lock: make D the last owner, then stall D and have I join
        drive(0, 1, 1, 0);
        oks("lk_seed", 4'b0100);
        tick();
        drive(0, 1, 0, 0);
        check("lk_addr0", mb.addr, DA);
        tick();
        drive(1, 1, 0, 0);
        check("lk_addr1", mb.addr, DA);
        oks("lk_hold1", 4'b0000);
        tick();
        drive(1, 1, 0, 0);
        check("lk_addr2", mb.addr, DA);
        tick();
        drive(1, 1, 1, 0);
        oks("lk_acc_d", 4'b0100);
        tick();
        drive(1, 1, 1, 0);
        check("lk_addr_i", mb.addr, IA);
        oks("lk_acc_i", 4'b1000);
        tick();
        // lock owner drops request: arbitration restarts at once
        drive(0, 1, 0, 0);
        tick();
        drive(1, 0, 1, 0);
        check("lk_drop_addr", mb.addr, IA);
        oks("lk_drop_acc", 4'b1000);
        tick();
        drive(0, 0, 0, 1);
        oks("lk_dr0", 4'b0001);
        tick();
        drive(0, 0, 0, 1);
        oks("lk_dr1", 4'b0001);
        tick();
        drive(0, 0, 0, 1);
        oks("lk_dr2", 4'b0010);
        tick();
        drive(0, 0, 0, 1);
        oks("lk_dr3", 4'b0010);
        tick();
        drive(0, 0, 0, 0);
        check("lk_busy", busy, 0);
        check("lk_stray", err_stray, 0);
        // reset mid-operation, then a late response is stray
        drive(1, 0, 1, 0);
        tick();
        drive(1, 0, 1, 0);
        tick();
        drive(1, 0, 0, 0);
        check("sr_busy_pre", busy, 1);
        #2 rst = 1'b0;
        #1;
        check("sr_mreq", mb.req, 0);
        check("sr_busy", busy, 0);
        mb.data_ok = 1;
        #1;
        oks("sr_oks_rst", 4'b0000);
        #2 rst = 1'b1;
        tick();
        drive(0, 0, 0, 1);
        oks("sr_late", 4'b0000);
        tick();
        drive(1, 1, 0, 0);
        check("sr_flag", err_stray, 1);
        check("sr_first_d", mb.addr, DA);
        tick();
        drive(0, 0, 0, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
